// File: rtl/mem_stage_if.sv
// rv32i_types: shared pipeline types for the rv32i datapath.
//   rv32i_control_word - per-instruction control/data word carried between
//                        pipeline latches.
// mem_stage_if: data-memory bus between the MEM stage and data memory.
//   data_mem_read    - read request
//   data_mem_write   - write request
//   data_mem_address - word-aligned byte address
//   data_mem_wdata   - lane-aligned store data
//   data_mem_mbe     - write byte enables (0 during reads)
//   data_mem_rdata   - read data, valid with data_mem_resp
//   data_mem_resp    - single-cycle completion pulse
//   modport master: MEM stage side; modport slave: memory side.
package rv32i_types;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
        logic [4:0]  rd;
        logic [31:0] alu_out;
        logic [31:0] rs2_data;
        logic        load_regfile;
        logic        data_mem_read;
        logic        data_mem_write;
        logic [31:0] data_memory_rdata;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
    } rv32i_control_word;

endpackage

interface mem_stage_if;

    logic        data_mem_read;
    logic        data_mem_write;
    logic [31:0] data_mem_address;
    logic [31:0] data_mem_wdata;
    logic [3:0]  data_mem_mbe;
    logic [31:0] data_mem_rdata;
    logic        data_mem_resp;

    modport master (
        output data_mem_read, data_mem_write, data_mem_address,
               data_mem_wdata, data_mem_mbe,
        input  data_mem_rdata, data_mem_resp
    );

    modport slave (
        input  data_mem_read, data_mem_write, data_mem_address,
               data_mem_wdata, data_mem_mbe,
        output data_mem_rdata, data_mem_resp
    );

endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 5-stage rv32i pipeline.
// Takes the EX/MEM control word, performs at most one data-memory
// transaction per instruction through a read/write/resp handshake,
// aligns store data, extracts and extends load data, and registers the
// finished control word into the MEM/WB latch.
// Ports:
//   clk          - rising-edge clock
//   rst          - asynchronous active-low reset
//   ex_mem_cw    - instruction from the EX/MEM latch
//   ex_mem_valid - ex_mem_cw is a real instruction
//   mem_stall    - hold upstream stages and EX/MEM this cycle
//   dmem         - data-memory bus (master side)
//   mem_wb_cw    - registered MEM/WB control word
//   mem_wb_valid - mem_wb_cw is a real instruction
//   misalign     - one-cycle pulse for a suppressed misaligned access
module mem_stage
    import rv32i_types::*;
(
    input  logic              clk,
    input  logic              rst,
    input  rv32i_control_word ex_mem_cw,
    input  logic              ex_mem_valid,
    output logic              mem_stall,
    mem_stage_if.master       dmem,
    output rv32i_control_word mem_wb_cw,
    output logic              mem_wb_valid,
    output logic              misalign
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t state, state_next;

    // Request registers, captured when an aligned memory op is accepted.
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_mbe;
    logic              req_read;
    logic              req_write;
    rv32i_control_word req_cw;

    // Decode of the incoming instruction.
    logic [2:0]  funct3;
    logic [1:0]  off;
    logic        mem_op;
    logic        bad_align;
    logic [3:0]  lane_mask;
    logic [31:0] store_data;

    always_comb begin
        funct3 = ex_mem_cw.instruction[14:12];
        off    = ex_mem_cw.alu_out[1:0];
        mem_op = ex_mem_valid &&
                 (ex_mem_cw.data_mem_read || ex_mem_cw.data_mem_write);

        // funct3[1:0]: 00 byte, 01 half, 1x word
        bad_align = ((funct3[1:0] == 2'b01) && off[0]) ||
                    (funct3[1] && (off != 2'b00));

        case (funct3[1:0])
            2'b00: begin
                lane_mask  = 4'b0001 << off;
                store_data = {4{ex_mem_cw.rs2_data[7:0]}};
            end
            2'b01: begin
                lane_mask  = 4'b0011 << off;
                store_data = {2{ex_mem_cw.rs2_data[15:0]}};
            end
            default: begin
                lane_mask  = 4'b1111;
                store_data = ex_mem_cw.rs2_data;
            end
        endcase
    end

    // Load extraction from the latched request.
    logic [1:0]  r_off;
    logic [31:0] r_shift;
    logic [7:0]  r_byte;
    logic [15:0] r_half;
    logic [31:0] load_data;

    always_comb begin
        r_off   = req_cw.alu_out[1:0];
        r_shift = dmem.data_mem_rdata >> {r_off, 3'b000};
        r_byte  = r_shift[7:0];
        r_half  = r_off[1] ? dmem.data_mem_rdata[31:16]
                           : dmem.data_mem_rdata[15:0];
        case (req_cw.instruction[14:12])
            3'b000:  load_data = {{24{r_byte[7]}}, r_byte};
            3'b001:  load_data = {{16{r_half[15]}}, r_half};
            3'b100:  load_data = {24'd0, r_byte};
            3'b101:  load_data = {16'd0, r_half};
            default: load_data = dmem.data_mem_rdata;
        endcase
    end

    // Next-state, stall and MEM/WB next values.
    rv32i_control_word wb_cw_next;
    logic              wb_valid_next;
    logic              misalign_next;
    logic              accept;

    always_comb begin
        state_next       = state;
        mem_stall        = 1'b0;
        accept           = 1'b0;
        misalign_next    = 1'b0;
        wb_cw_next       = ex_mem_cw;
        wb_cw_next.rmask = '0;
        wb_cw_next.wmask = '0;
        wb_valid_next    = ex_mem_valid;

        case (state)
            IDLE: begin
                if (mem_op) begin
                    if (bad_align) begin
                        wb_cw_next.load_regfile   = 1'b0;
                        wb_cw_next.data_mem_read  = 1'b0;
                        wb_cw_next.data_mem_write = 1'b0;
                        misalign_next             = 1'b1;
                    end else begin
                        accept        = 1'b1;
                        mem_stall     = 1'b1;
                        wb_cw_next    = '0;
                        wb_valid_next = 1'b0;
                        state_next    = BUSY;
                    end
                end
            end
            BUSY: begin
                if (dmem.data_mem_resp) begin
                    wb_cw_next    = req_cw;
                    wb_valid_next = 1'b1;
                    if (req_read)
                        wb_cw_next.data_memory_rdata = load_data;
                    state_next = IDLE;
                end else begin
                    mem_stall     = 1'b1;
                    wb_cw_next    = '0;
                    wb_valid_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_addr  <= '0;
            req_wdata <= '0;
            req_mbe   <= '0;
            req_read  <= 1'b0;
            req_write <= 1'b0;
            req_cw    <= '0;
        end else if (accept) begin
            req_addr     <= {ex_mem_cw.alu_out[31:2], 2'b00};
            req_wdata    <= ex_mem_cw.data_mem_write ? store_data : '0;
            req_mbe      <= ex_mem_cw.data_mem_write ? lane_mask : '0;
            req_read     <= ex_mem_cw.data_mem_read;
            req_write    <= ex_mem_cw.data_mem_write;
            req_cw       <= ex_mem_cw;
            req_cw.rmask <= ex_mem_cw.data_mem_read ? lane_mask : '0;
            req_cw.wmask <= ex_mem_cw.data_mem_write ? lane_mask : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_wb_cw    <= '0;
            mem_wb_valid <= 1'b0;
            misalign     <= 1'b0;
        end else begin
            mem_wb_cw    <= wb_cw_next;
            mem_wb_valid <= wb_valid_next;
            misalign     <= misalign_next;
        end
    end

    // Requests come only from the latched registers while BUSY.
    always_comb begin
        dmem.data_mem_read    = (state == BUSY) && req_read;
        dmem.data_mem_write   = (state == BUSY) && req_write;
        dmem.data_mem_address = req_addr;
        dmem.data_mem_wdata   = req_wdata;
        dmem.data_mem_mbe     = (state == BUSY) ? req_mbe : '0;
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage.
// A behavioural memory answers requests after a programmable latency;
// expected MEM/WB words are queued when an instruction is driven and
// checked when mem_wb_valid appears.
module tb_mem_stage;
    import rv32i_types::*;

    logic              clk;
    logic              rst;
    rv32i_control_word ex_mem_cw;
    logic              ex_mem_valid;
    logic              mem_stall;
    rv32i_control_word mem_wb_cw;
    logic              mem_wb_valid;
    logic              misalign;

    mem_stage_if dmem ();

    mem_stage dut (
        .clk          (clk),
        .rst          (rst),
        .ex_mem_cw    (ex_mem_cw),
        .ex_mem_valid (ex_mem_valid),
        .mem_stall    (mem_stall),
        .dmem         (dmem),
        .mem_wb_cw    (mem_wb_cw),
        .mem_wb_valid (mem_wb_valid),
        .misalign     (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned nvec  = 0;
    int unsigned nfail = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic        chk_mask;
        logic        lrf;
        logic        rd;
        logic        wr;
    } exp_t;

    exp_t sb_q[$];

    // Memory model controls (written only by the main sequence).
    int unsigned mem_lat   = 0;
    logic [31:0] mem_data  = '0;
    int unsigned stray_req = 0;
    // Memory model state (written only by the responder).
    int unsigned stray_done = 0;
    int unsigned cnt        = 0;

    task automatic chk(input string tag, input logic [191:0] obs,
                       input logic [191:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Responder: updates resp 2 time units after each rising edge.
    always @(posedge clk) begin
        #2;
        dmem.data_mem_resp = 1'b0;
        if (stray_done != stray_req) begin
            stray_done          = stray_req;
            dmem.data_mem_resp  = 1'b1;
            dmem.data_mem_rdata = 32'hBAD0_BAD0;
        end else if ((dmem.data_mem_read || dmem.data_mem_write) && mem_lat != 0) begin
            cnt++;
            if (cnt == mem_lat) begin
                dmem.data_mem_resp  = 1'b1;
                dmem.data_mem_rdata = mem_data;
                cnt = 0;
            end
        end else begin
            cnt = 0;
        end
    end

    // MEM/WB scoreboard monitor.
    always @(negedge clk) begin
        if (mem_wb_valid === 1'b1) begin
            nvec++;
            assert (sb_q.size() > 0) else begin
                nfail++;
                $error("FAIL wb_unexpected: observed pc %0h expected none", mem_wb_cw.pc);
            end
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                chk("wb_pc",   mem_wb_cw.pc, e.pc);
                chk("wb_data", mem_wb_cw.data_memory_rdata, e.data);
                chk("wb_lrf",  mem_wb_cw.load_regfile, e.lrf);
                chk("wb_rd",   mem_wb_cw.data_mem_read, e.rd);
                chk("wb_wr",   mem_wb_cw.data_mem_write, e.wr);
                if (e.chk_mask) begin
                    chk("wb_rmask", mem_wb_cw.rmask, e.rmask);
                    chk("wb_wmask", mem_wb_cw.wmask, e.wmask);
                end
            end
        end
    end

    function automatic rv32i_control_word mk(input logic [31:0] pc,
            input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] rs2,
            input logic lrf, input logic rd, input logic wr);
        rv32i_control_word c;
        c = '0;
        c.pc             = pc;
        c.instruction    = {17'd0, f3, 12'h0A3};
        c.rd             = pc[6:2];
        c.alu_out        = alu;
        c.rs2_data       = rs2;
        c.load_regfile   = lrf;
        c.data_mem_read  = rd;
        c.data_mem_write = wr;
        return c;
    endfunction

    task automatic push(input rv32i_control_word c, input logic [31:0] data,
                        input logic [3:0] rm, input logic [3:0] wm,
                        input logic cm, input logic lrf, input logic rd, input logic wr);
        exp_t e;
        e.pc = c.pc; e.data = data; e.rmask = rm; e.wmask = wm;
        e.chk_mask = cm; e.lrf = lrf; e.rd = rd; e.wr = wr;
        sb_q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic drive(input rv32i_control_word c, input logic v);
        ex_mem_cw    = c;
        ex_mem_valid = v;
    endtask

    // Entered in cycle 0 with cw already driven and settled; leaves in
    // cycle k+1 with nxt driven and settled.
    task automatic run_mem(input string tag, input rv32i_control_word c,
            input int unsigned lat, input logic [31:0] rdata,
            input logic [31:0] exp_data, input logic [3:0] exp_mask,
            input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
            input rv32i_control_word nxt, input logic nxt_v);
        mem_lat  = lat;
        mem_data = rdata;
        push(c, exp_data, c.data_mem_read ? exp_mask : 4'b0000,
             c.data_mem_write ? exp_mask : 4'b0000, 1'b1,
             c.load_regfile, c.data_mem_read, c.data_mem_write);
        chk({tag, "_c0_stall"}, mem_stall, 1'b1);
        chk({tag, "_c0_req"}, {dmem.data_mem_read, dmem.data_mem_write}, 2'b00);
        for (int unsigned k = 1; k <= lat; k++) begin
            cyc();
            settle();
            chk({tag, "_read"},  dmem.data_mem_read, c.data_mem_read);
            chk({tag, "_write"}, dmem.data_mem_write, c.data_mem_write);
            chk({tag, "_addr"},  dmem.data_mem_address, exp_addr);
            chk({tag, "_mbe"},   dmem.data_mem_mbe, c.data_mem_write ? exp_mask : 4'b0000);
            if (c.data_mem_write)
                chk({tag, "_wdata"}, dmem.data_mem_wdata, exp_wdata);
            chk({tag, "_stall"}, mem_stall, (k < lat) ? 1'b1 : 1'b0);
            chk({tag, "_wbv_busy"}, mem_wb_valid, 1'b0);
        end
        cyc();
        drive(nxt, nxt_v);
        settle();
        chk({tag, "_wbv_done"}, mem_wb_valid, 1'b1);
        chk({tag, "_gap"}, {dmem.data_mem_read, dmem.data_mem_write}, 2'b00);
    endtask

    rv32i_control_word bubble;
    rv32i_control_word c_lw, c_sb, c_sh, c_lh, c_lhu, c_lb, c_lb3, c_lbu;
    rv32i_control_word c_mis_sw, c_mis_lw, c_rst_lw, c_add, c_sw2, c_lw2;

    initial begin
        bubble = '0;
        rst = 1'b0;
        drive(bubble, 1'b0);

        // Reset state
        repeat (2) @(posedge clk);
        #4;
        chk("rst_wb_valid", mem_wb_valid, 1'b0);
        chk("rst_wb_cw",    mem_wb_cw, '0);
        chk("rst_misalign", misalign, 1'b0);
        chk("rst_req",      {dmem.data_mem_read, dmem.data_mem_write}, 2'b00);
        chk("rst_stall",    mem_stall, 1'b0);
        cyc();
        rst = 1'b1;

        // Loads/stores with various widths, chained through run_mem
        c_lw  = mk(32'h0000_0010, 3'b010, 32'h1000_0004, 32'h0, 1'b1, 1'b1, 1'b0);
        c_sb  = mk(32'h0000_0014, 3'b000, 32'h0000_2002, 32'h0000_00A5, 1'b0, 1'b0, 1'b1);
        c_sh  = mk(32'h0000_0018, 3'b001, 32'h0000_6002, 32'h1234_BEEF, 1'b0, 1'b0, 1'b1);
        c_lh  = mk(32'h0000_001C, 3'b001, 32'h0000_5002, 32'h0, 1'b1, 1'b1, 1'b0);
        c_lhu = mk(32'h0000_0020, 3'b101, 32'h0000_5006, 32'h0, 1'b1, 1'b1, 1'b0);
        c_lb  = mk(32'h0000_0024, 3'b000, 32'h0000_5008, 32'h0, 1'b1, 1'b1, 1'b0);
        c_lb3 = mk(32'h0000_0028, 3'b000, 32'h0000_500B, 32'h0, 1'b1, 1'b1, 1'b0);
        c_lbu = mk(32'h0000_002C, 3'b100, 32'h0000_500D, 32'h0, 1'b1, 1'b1, 1'b0);

        cyc();
        drive(c_lw, 1'b1);
        settle();
        run_mem("lw",  c_lw,  3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111,
                32'h1000_0004, 32'h0, c_sb, 1'b1);
        run_mem("sb",  c_sb,  2, 32'h0, 32'h0, 4'b0100,
                32'h0000_2000, 32'hA5A5_A5A5, c_sh, 1'b1);
        run_mem("sh",  c_sh,  1, 32'h0, 32'h0, 4'b1100,
                32'h0000_6000, 32'hBEEF_BEEF, c_lh, 1'b1);
        run_mem("lh",  c_lh,  1, 32'h8000_1234, 32'hFFFF_8000, 4'b1100,
                32'h0000_5000, 32'h0, c_lhu, 1'b1);
        run_mem("lhu", c_lhu, 2, 32'h8000_1234, 32'h0000_8000, 4'b1100,
                32'h0000_5004, 32'h0, c_lb, 1'b1);
        run_mem("lb",  c_lb,  1, 32'h8000_1234, 32'h0000_0034, 4'b0001,
                32'h0000_5008, 32'h0, c_lb3, 1'b1);
        run_mem("lb3", c_lb3, 1, 32'hF000_1234, 32'hFFFF_FFF0, 4'b1000,
                32'h0000_5008, 32'h0, c_lbu, 1'b1);
        run_mem("lbu", c_lbu, 1, 32'h0000_AB00, 32'h0000_00AB, 4'b0010,
                32'h0000_500C, 32'h0, bubble, 1'b0);

        // Misaligned sw and lw: no request, one cycle, misalign pulse
        c_mis_sw = mk(32'h0000_0030, 3'b010, 32'h0000_3001, 32'h7777_7777, 1'b0, 1'b0, 1'b1);
        c_mis_lw = mk(32'h0000_0034, 3'b010, 32'h0000_3002, 32'h0, 1'b1, 1'b1, 1'b0);
        cyc();
        drive(c_mis_sw, 1'b1);
        push(c_mis_sw, 32'h0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("mis_sw_stall", mem_stall, 1'b0);
        chk("mis_sw_req",   {dmem.data_mem_read, dmem.data_mem_write}, 2'b00);
        cyc();
        drive(c_mis_lw, 1'b1);
        push(c_mis_lw, 32'h0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("mis_sw_pulse", misalign, 1'b1);
        chk("mis_sw_wbv",   mem_wb_valid, 1'b1);
        chk("mis_lw_stall", mem_stall, 1'b0);
        chk("mis_lw_req",   {dmem.data_mem_read, dmem.data_mem_write}, 2'b00);
        cyc();
        drive(bubble, 1'b0);
        settle();
        chk("mis_lw_pulse", misalign, 1'b1);
        chk("mis_lw_lrf",   mem_wb_cw.load_regfile, 1'b0);
        chk("mis_lw_req",   {dmem.data_mem_read, dmem.data_mem_write}, 2'b00);
        cyc();
        settle();
        chk("mis_end", misalign, 1'b0);
        chk("mis_end_wbv", mem_wb_valid, 1'b0);

        // Reset asserted two cycles into a read that never completes
        c_rst_lw = mk(32'h0000_0040, 3'b010, 32'h0000_7000, 32'h0, 1'b1, 1'b1, 1'b0);
        mem_lat = 0;
        cyc();
        drive(c_rst_lw, 1'b1);
        settle();
        chk("rb_c0_stall", mem_stall, 1'b1);
        cyc();
        settle();
        chk("rb_c1_read", dmem.data_mem_read, 1'b1);
        cyc();
        settle();
        chk("rb_c2_read", dmem.data_mem_read, 1'b1);
        chk("rb_c2_stall", mem_stall, 1'b1);
        #2;
        rst = 1'b0;
        drive(bubble, 1'b0);
        #1;
        chk("rb_drop_read",  dmem.data_mem_read, 1'b0);
        chk("rb_drop_stall", mem_stall, 1'b0);
        chk("rb_drop_wbv",   mem_wb_valid, 1'b0);
        cyc();
        cyc();
        rst = 1'b1;
        stray_req++;
        cyc();
        settle();
        chk("stray_stall", mem_stall, 1'b0);
        cyc();
        settle();
        chk("stray_wbv",  mem_wb_valid, 1'b0);
        chk("stray_req",  {dmem.data_mem_read, dmem.data_mem_write}, 2'b00);
        c_add = mk(32'h0000_0050, 3'b000, 32'h0000_0123, 32'h0, 1'b1, 1'b0, 1'b0);
        cyc();
        drive(c_add, 1'b1);
        push(c_add, 32'h0, 4'b0, 4'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        settle();
        chk("post_rst_stall", mem_stall, 1'b0);
        cyc();
        drive(bubble, 1'b0);
        settle();
        chk("post_rst_wbv", mem_wb_valid, 1'b1);

        // Back-to-back: four adds, then sw and lw with immediate resp
        for (int unsigned i = 0; i < 4; i++) begin
            c_add = mk(32'h0000_0100 + 32'(i * 4), 3'b000, 32'h0000_1000 + 32'(i),
                       32'h0, 1'b1, 1'b0, 1'b0);
            cyc();
            drive(c_add, 1'b1);
            push(c_add, 32'h0, 4'b0, 4'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            settle();
            chk("add_stall", mem_stall, 1'b0);
            if (i > 0)
                chk("add_wbv", mem_wb_valid, 1'b1);
        end
        c_sw2 = mk(32'h0000_0110, 3'b010, 32'h0000_4008, 32'h1122_3344, 1'b0, 1'b0, 1'b1);
        c_lw2 = mk(32'h0000_0114, 3'b010, 32'h0000_4008, 32'h0, 1'b1, 1'b1, 1'b0);
        cyc();
        drive(c_sw2, 1'b1);
        settle();
        chk("add_last_wbv", mem_wb_valid, 1'b1);
        run_mem("b2b_sw", c_sw2, 1, 32'h0, 32'h0, 4'b1111,
                32'h0000_4008, 32'h1122_3344, c_lw2, 1'b1);
        run_mem("b2b_lw", c_lw2, 1, 32'h5566_7788, 32'h5566_7788, 4'b1111,
                32'h0000_4008, 32'h0, bubble, 1'b0);

        cyc();
        settle();
        chk("end_wbv", mem_wb_valid, 1'b0);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage rv32i pipeline. Consumes the EX/MEM `rv32i_control_word` and drives the single-ported data memory through a read/write/resp handshake. Generates byte masks, aligns store data, and sign/zero-extends load data. Registers the completed control word into the MEM/WB latch, and stalls upstream stages while a memory transaction is outstanding.

## Interface
- No parameters; widths are fixed by `rv32i_types`.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset (asserted when 0).
- `ex_mem_cw` in `rv32i_control_word`: instruction from the EX/MEM latch.
- `ex_mem_valid` in 1: `ex_mem_cw` holds a real instruction (0 = bubble).
- `mem_stall` out 1: hold IF/ID/EX and the EX/MEM latch this cycle.
- `data_mem_read` out 1: read request.
- `data_mem_write` out 1: write request.
- `data_mem_address` out 32: word-aligned address, `{alu_out[31:2],2'b00}`.
- `data_mem_wdata` out 32: lane-aligned store data.
- `data_mem_mbe` out 4: byte enables for writes; 4'b0000 during reads.
- `data_mem_rdata` in 32: read data, valid when `data_mem_resp`=1.
- `data_mem_resp` in 1: single-cycle completion pulse.
- `mem_wb_cw` out `rv32i_control_word`: registered MEM/WB control word.
- `mem_wb_valid` out 1: `mem_wb_cw` is a real instruction.
- `misalign` out 1: registered one-cycle pulse flagging a suppressed misaligned access.

## Operation
- Access width comes from `instruction[14:12]`; the byte offset is `off = alu_out[1:0]`.
- **Memory op**: `ex_mem_valid && (data_mem_read || data_mem_write)` in the input cw.
- **Misalignment**:
  - Halfword access with `off[0]=1` is misaligned.
  - Word access with `off≠0` is misaligned.
  - A misaligned op issues no memory request.
  - It passes to MEM/WB in one cycle with `load_regfile`, `data_mem_read`, and `data_mem_write` cleared.
  - It raises `misalign` for that cycle.
- **Store lanes**:
  - sb: mbe = `4'b0001<<off`, wdata = byte replicated ×4.
  - sh: mbe = `4'b0011<<off`, wdata = half replicated ×2.
  - sw: mbe = 4'b1111, wdata = `rs2_data`.
- **Load extract**: select the byte/half from `data_mem_rdata` at `off`.
  - lb/lh: sign-extend. lbu/lhu: zero-extend. lw: pass through.
  - The result is written into `data_memory_rdata` of `mem_wb_cw`.
- The `rmask` (loads) or `wmask` (stores) field of `mem_wb_cw` is set to the computed mask. For non-memory ops both are 0.
- All other cw fields pass through unchanged.
- **FSM** has two states, IDLE and BUSY.
  - **IDLE**:
    - Non-memory op or bubble: loaded into MEM/WB next edge; `mem_stall`=0.
    - Aligned memory op: latch address, wdata, mbe, read/write, and cw into request registers; assert `mem_stall`; load a bubble into MEM/WB; go to BUSY.
  - **BUSY**:
    - `data_mem_read`/`data_mem_write` are driven from the request registers, held constant until resp.
    - Without resp: `mem_stall`=1 and MEM/WB loads a bubble.
    - With resp: `mem_stall`=0; MEM/WB loads the latched cw with load data; go to IDLE.
- In IDLE, `data_mem_read`/`data_mem_write` are 0; requests never originate combinationally from `ex_mem_cw`.

## Timing
- **Reset values**:
  - State IDLE; all request registers 0.
  - `mem_wb_cw` all-zero; `mem_wb_valid`=0; `misalign`=0.
  - `data_mem_read`=`data_mem_write`=0.
  - `mem_stall`=0, since it is combinational from IDLE with `ex_mem_valid` gated.
- **Non-memory latency**: 1 cycle from EX/MEM to MEM/WB.
- **Memory op** (accepted in cycle 0, resp arriving in cycle k≥1):
  - Request is visible from cycle 1 through k.
  - `mem_stall`=1 for cycles 0..k−1 and 0 in cycle k.
  - `mem_wb_valid`=1 in cycle k+1.
  - Minimum total latency: 2 cycles.
- A resp in IDLE is ignored.
- The EX/MEM input is held stable while `mem_stall`=1. The next instruction is presented in cycle k+1 and may itself be a memory op, so back-to-back requests have a 1-cycle IDLE gap.
- Reset asserted in BUSY:
  - Request is dropped immediately (asynchronous), with no completion.
  - A resp arriving after reset is ignored.

## Test plan
- **lw**: `alu_out`=0x1000_0004, resp after 3 cycles with rdata=0xDEAD_BEEF.
  - Address 0x1000_0004, mbe 0; `mem_stall` high for 3 cycles.
  - `mem_wb_cw.data_memory_rdata`=0xDEAD_BEEF and `rmask`=4'b1111 in cycle 4.
- **sb**: `rs2_data`=0x0000_00A5, `alu_out`=0x2002.
  - Address 0x2000, mbe 4'b0100, wdata 0xA5A5_A5A5, `wmask`=4'b0100.
- **lh/lhu**: off=2, rdata=0x8000_1234.
  - lh yields 0xFFFF_8000; lhu yields 0x0000_8000.
  - lb with off=0 yields 0x0000_0034.
- **Misaligned**: sw with `alu_out`=0x3001.
  - No read/write asserted; `misalign` pulses once.
  - `mem_wb_cw.load_regfile`=0; latency 1; no stall.
- **Reset in BUSY**: drop `rst` to 0 two cycles into a read.
  - `data_mem_read`, `mem_stall`, `mem_wb_valid` go to 0 immediately.
  - After release, a non-memory op flows through in 1 cycle.
- **Back-to-back**: four add ops, then sw, then lw, with resp immediate (k=1).
  - The adds arrive at MEM/WB on consecutive cycles.
  - sw and lw complete at 2 cycles each, with one IDLE gap between requests.
